// File: rtl/argmax_float.sv
// Sequential argmax over N packed IEEE-754 single-precision values, one element per cycle.
// NaNs are skipped; ties resolve to the lowest index; start restarts the scan from any state.
module argmax_float #(
  parameter int N  = 10,
  parameter int S  = 32,
  parameter int IW = 4
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           start_i,
  input  logic [S*N-1:0] x_i,
  output logic [IW-1:0]  idx_o,
  output logic [S-1:0]   max_o,
  output logic           all_nan_o,
  output logic           busy_o,
  output logic           done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [S*N-1:0] x_q;
  logic [S-1:0]   cur_max_q;
  logic [IW-1:0]  cur_idx_q;
  logic           cur_valid_q;
  logic [IW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  logic [S-1:0]   max_q;
  logic           all_nan_q;
  logic           busy_q;
  logic           done_q;

  function automatic logic is_nan(input logic [S-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Strict a > b on non-NaN operands; +0 and -0 compare equal.
  function automatic logic f_gt(input logic [S-1:0] a, input logic [S-1:0] b);
    logic res;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) res = 1'b0;
    else if (a[31] != b[31])                      res = ~a[31];
    else if (!a[31])                              res = (a[30:0] > b[30:0]);
    else                                          res = (a[30:0] < b[30:0]);
    return res;
  endfunction

  logic [S-1:0]  elem [N];
  logic [S-1:0]  e_cur;
  logic [S-1:0]  e0_in;
  logic          take;
  logic          last;
  logic [S-1:0]  max_d;
  logic [IW-1:0] idx_d;
  logic          valid_d;

  always_comb begin
    for (int i = 0; i < N; i++) elem[i] = x_q[i*S +: S];
  end

  always_comb begin
    e0_in   = x_i[S-1:0];
    e_cur   = elem[cnt_q];
    last    = (cnt_q == IW'(N-1));
    take    = !is_nan(e_cur) && (!cur_valid_q || f_gt(e_cur, cur_max_q));
    max_d   = take ? e_cur : cur_max_q;
    idx_d   = take ? cnt_q : cur_idx_q;
    valid_d = take | cur_valid_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      cur_max_q   <= '0;
      cur_idx_q   <= '0;
      cur_valid_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      all_nan_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (start_i) begin
      x_q         <= x_i;
      cur_max_q   <= e0_in;
      cur_idx_q   <= '0;
      cur_valid_q <= !is_nan(e0_in);
      cnt_q       <= IW'(1);
      if (N == 1) begin
        state_q   <= ST_DONE;
        idx_q     <= '0;
        max_q     <= e0_in;
        all_nan_q <= is_nan(e0_in);
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
      end else if (state_q == ST_SCAN && last) begin
        // Back-to-back: the finishing scan still publishes while the next one begins.
        state_q   <= ST_SCAN;
        idx_q     <= idx_d;
        max_q     <= max_d;
        all_nan_q <= !valid_d;
        busy_q    <= 1'b1;
        done_q    <= 1'b1;
      end else begin
        state_q <= ST_SCAN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_SCAN: begin
          cur_max_q   <= max_d;
          cur_idx_q   <= idx_d;
          cur_valid_q <= valid_d;
          if (last) begin
            state_q   <= ST_DONE;
            idx_q     <= idx_d;
            max_q     <= max_d;
            all_nan_q <= !valid_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= 1'b0;
          end
        end
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idx_o     = idx_q;
  assign max_o     = max_q;
  assign all_nan_o = all_nan_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_argmax_float.sv
// Directed table-driven bench for argmax_float plus restart, reset and back-to-back sequences.
module tb_argmax_float;
  localparam int N  = 10;
  localparam int S  = 32;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [S*N-1:0] x;
  logic [IW-1:0]  idx;
  logic [S-1:0]   mx;
  logic           all_nan;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  argmax_float #(.N(N), .S(S), .IW(IW)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .x_i       (x),
    .idx_o     (idx),
    .max_o     (mx),
    .all_nan_o (all_nan),
    .busy_o    (busy),
    .done_o    (done)
  );

  typedef struct {
    string          name;
    logic [S*N-1:0] x;
    logic [IW-1:0]  idx;
    logic [S-1:0]   mx;
    logic           an;
  } vec_t;

  vec_t tbl [9];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [S*N-1:0] mkv(input logic [31:0] fill,
                                         input int i1, input logic [31:0] v1,
                                         input int i2, input logic [31:0] v2);
    logic [S*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*S +: S] = fill;
    if (i1 >= 0) v[i1*S +: S] = v1;
    if (i2 >= 0) v[i2*S +: S] = v2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Start is sampled at the returned-from posedge (edge 0); x is then scrambled.
  task automatic pulse_start(input logic [S*N-1:0] v);
    @(negedge clk);
    x     = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = '1;
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = e;
        break;
      end
    end
  endtask

  initial begin
    int k;
    tbl[0] = '{"basic",    mkv(32'h3F000000, 6, 32'h3F7AE148, -1, 0),         4'd6, 32'h3F7AE148, 1'b0};
    tbl[1] = '{"negzero",  mkv(32'hC0000000, 3, 32'h80000000, 7, 32'h00000000), 4'd3, 32'h80000000, 1'b0};
    tbl[2] = '{"neg",      mkv(32'hC0000000, 4, 32'hBF800000, -1, 0),         4'd4, 32'hBF800000, 1'b0};
    tbl[3] = '{"nan_inf",  mkv(32'h3F800000, 0, 32'h7FC00000, 2, 32'h7F800000), 4'd2, 32'h7F800000, 1'b0};
    tbl[4] = '{"all_nan",  mkv(32'h7FC00000, -1, 0, -1, 0),                   4'd0, 32'h7FC00000, 1'b1};
    tbl[5] = '{"all_tie",  mkv(32'h3F800000, -1, 0, -1, 0),                   4'd0, 32'h3F800000, 1'b0};
    tbl[6] = '{"last",     mkv(32'h3F800000, 9, 32'h40000000, -1, 0),         4'd9, 32'h40000000, 1'b0};
    tbl[7] = '{"denorm",   mkv(32'hFF800000, 5, 32'h00000001, -1, 0),         4'd5, 32'h00000001, 1'b0};
    tbl[8] = '{"neg_nan",  mkv(32'hBF800000, 0, 32'hFFC00000, 1, 32'hFFC00000) | mkv(32'h0, 8, 32'hBF000000, -1, 0),
               4'd8, 32'hBF000000, 1'b0};
    // Element 8 of the last entry: OR of 0xBF800000 and 0xBF000000 is 0xBF800000, so patch it directly.
    tbl[8].x[8*S +: S] = 32'hBF000000;

    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_max", mx, 32'd0);
    chk("rst_flags", {29'd0, all_nan, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      pulse_start(tbl[t].x);
      chk({tbl[t].name, "_busy_e0"}, 32'(busy), 32'd1);
      chk({tbl[t].name, "_done_e0"}, 32'(done), 32'd0);
      wait_done(k);
      chk({tbl[t].name, "_latency"}, k, 32'd9);
      chk({tbl[t].name, "_idx"}, 32'(idx), 32'(tbl[t].idx));
      chk({tbl[t].name, "_max"}, mx, tbl[t].mx);
      chk({tbl[t].name, "_all_nan"}, 32'(all_nan), 32'(tbl[t].an));
      chk({tbl[t].name, "_busy_end"}, 32'(busy), 32'd0);
    end

    // Restart at edge 4: vector A (max at 8) must never be reported.
    pulse_start(mkv(32'h3F800000, 8, 32'h40000000, -1, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("restart_done_e3", 32'(done), 32'd0);
    pulse_start(mkv(32'h3F800000, 1, 32'h40400000, -1, 0));
    wait_done(k);
    chk("restart_latency", k, 32'd9);
    chk("restart_idx", 32'(idx), 32'd1);
    chk("restart_max", mx, 32'h40400000);

    // Asynchronous reset mid-scan.
    pulse_start(tbl[0].x);
    repeat (5) @(posedge clk);
    #1;
    chk("prerst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_idx", 32'(idx), 32'd0);
    chk("rst_mid_max", mx, 32'd0);
    chk("rst_mid_flags", {29'd0, all_nan, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(k);
    chk("no_done_after_rst", k, -1);

    // Back-to-back: second start sampled at edge 9 of the first scan.
    pulse_start(tbl[0].x);
    repeat (8) @(posedge clk);
    pulse_start(tbl[2].x);
    chk("b2b_done_e9", 32'(done), 32'd1);
    chk("b2b_idx_e9", 32'(idx), 32'd6);
    chk("b2b_max_e9", mx, 32'h3F7AE148);
    @(posedge clk);
    #1;
    chk("b2b_done_e10", 32'(done), 32'd0);
    chk("b2b_busy_e10", 32'(busy), 32'd1);
    chk("b2b_idx_hold", 32'(idx), 32'd6);
    wait_done(k);
    chk("b2b_latency2", k, 32'd8);
    chk("b2b_idx2", 32'(idx), 32'd4);
    chk("b2b_max2", mx, 32'hBF800000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
